logic_unit_pipe: RTL

- Parametrised, pipelined successor to the combinational 8-bit logic unit.
- Accepts one operand pair plus a 3-bit opcode per handshake and returns one selected bitwise result two cycles later.
- Carries full valid/ready backpressure, optional result flags and a transaction counter.
- Sits between the ALU operand mux and the ALU result mux.

---
 rtl/logic_unit_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage elastic pipeline applying one of eight bitwise ops to A/B.
// Build option LU_FLAGS_EN adds registered zero/ones/parity flags; without it they read 0.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_par,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOT_A = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    logic             s1_valid;
    logic             s2_valid;
    logic             s1_adv;
    logic             s2_adv;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_res;
    logic [WIDTH-1:0] y_q;
    logic [CNT_W-1:0] cnt_q;

    // No skid buffer: S1 only takes new data when it can hand its own content on.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;
    assign Y         = y_q;
    assign txn_cnt   = cnt_q;

    always_comb begin
        s1_res = '0;
        case (s1_op)
            OP_AND:    s1_res = s1_a & s1_b;
            OP_OR:     s1_res = s1_a | s1_b;
            OP_NAND:   s1_res = ~(s1_a & s1_b);
            OP_NOR:    s1_res = ~(s1_a | s1_b);
            OP_XOR:    s1_res = s1_a ^ s1_b;
            OP_XNOR:   s1_res = ~(s1_a ^ s1_b);
            OP_NOT_A:  s1_res = ~s1_a;
            OP_PASS_B: s1_res = s1_b;
            default:   s1_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_AND;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= A;
                s1_b  <= B;
                s1_op <= op_e'(op);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            y_q      <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                y_q <= s1_res;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (s2_valid && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

`ifdef LU_FLAGS_EN
    logic zero_q;
    logic ones_q;
    logic par_q;

    // Loaded on the same enable as Y so the flags always describe the visible result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            ones_q <= 1'b0;
            par_q  <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            zero_q <= (s1_res == '0);
            ones_q <= (s1_res == '1);
            par_q  <= ^s1_res;
        end
    end

    assign flag_zero = zero_q;
    assign flag_ones = ones_q;
    assign flag_par  = par_q;
`else
    assign flag_zero = 1'b0;
    assign flag_ones = 1'b0;
    assign flag_par  = 1'b0;
`endif

endmodule
